// File: rtl/irq_agg_pkg.sv
// Shared constants for the interrupt aggregator: register word addresses,
// the maximum source count and the ACTIVE register layout.
package irq_agg_pkg;

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_PENDING  = 3'd1;
   localparam logic [2:0] ADDR_ENABLE   = 3'd2;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
   localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
   localparam logic [2:0] ADDR_FORCE    = 3'd5;

   localparam int N_SRC_MAX        = 16;
   localparam int ACTIVE_VALID_BIT = 15;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder feeding the ACTIVE register.
module irq_prio_enc
   import irq_agg_pkg::*;
#(
   parameter int N_SRC = 8
)(
   input  logic [N_SRC-1:0] i_req,
   output logic             o_valid,
   output logic [3:0]       o_idx
);

   // Scanning from the top down lets the lowest set index overwrite the rest.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 4'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_idx   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: captures edge/level requests into sticky pending bits,
// masks them into one registered irq and exposes state over a 16-bit slave.
module irq_aggregator
   import irq_agg_pkg::*;
#(
   parameter int N_SRC = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [15:0]      writedata,
   output logic [15:0]      readdata,
   output logic             irq
);

   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_src_d;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_enable;
   logic [N_SRC-1:0] r_edge_sel;

   logic                 w_wr;
   logic [N_SRC-1:0]     w_wdata;
   logic [N_SRC-1:0]     w_clr;
   logic [N_SRC-1:0]     w_force;
   logic [N_SRC-1:0]     w_rise;
   logic [N_SRC-1:0]     w_set;
   logic                 w_act_valid;
   logic [3:0]           w_act_idx;
   logic [N_SRC_MAX-1:0] w_rdata;

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = N_SRC'(writedata);
   assign w_clr   = (w_wr && address == ADDR_PENDING) ? w_wdata : '0;
   assign w_force = (w_wr && address == ADDR_FORCE)   ? w_wdata : '0;
   assign w_rise  = r_src_q & ~r_src_d;
   // A still-high level source re-asserts here, so its clear never sticks.
   assign w_set   = (r_edge_sel & w_rise) | (~r_edge_sel & r_src_q) | w_force;

   irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .i_req   (r_pending & r_enable),
      .o_valid (w_act_valid),
      .o_idx   (w_act_idx)
   );

   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_STATUS:   w_rdata = N_SRC_MAX'(r_src_q);
         ADDR_PENDING:  w_rdata = N_SRC_MAX'(r_pending);
         ADDR_ENABLE:   w_rdata = N_SRC_MAX'(r_enable);
         ADDR_EDGE_SEL: w_rdata = N_SRC_MAX'(r_edge_sel);
         ADDR_ACTIVE: begin
            if (w_act_valid) begin
               w_rdata                   = N_SRC_MAX'(w_act_idx);
               w_rdata[ACTIVE_VALID_BIT] = 1'b1;
            end
         end
         default:       w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_q    <= '0;
         r_src_d    <= '0;
         r_pending  <= '0;
         r_enable   <= '0;
         r_edge_sel <= '0;
         readdata   <= '0;
         irq        <= 1'b0;
      end else begin
         r_src_q   <= src;
         r_src_d   <= r_src_q;
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_wr && address == ADDR_ENABLE)   r_enable   <= w_wdata;
         if (w_wr && address == ADDR_EDGE_SEL) r_edge_sel <= w_wdata;
         readdata  <= w_rdata;
         irq       <= |(r_pending & r_enable);
      end
   end

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: directed register/source sequences, a per-bit
// behavioural model compared every cycle, and literal expectations per scenario.
module tb_irq_aggregator;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  src;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [15:0]   writedata;
   logic [15:0]   readdata;
   logic          irq;

   int n_checks = 0;
   int n_errors = 0;

   irq_aggregator #(.N_SRC(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .src        (src),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural model: sampled-source history plus register image
   logic [N-1:0] m_seen1;   // src as sampled at the last edge
   logic [N-1:0] m_seen2;   // src as sampled the edge before that
   logic [N-1:0] m_pend, m_en, m_es;
   logic [15:0]  m_rd;
   logic         m_irq;
   bit           m_live = 1'b0;

   function automatic logic [15:0] model_read(input logic [2:0] a);
      logic [15:0] v;
      v = 16'h0000;
      case (a)
         3'd0: v = 16'(m_seen1);
         3'd1: v = 16'(m_pend);
         3'd2: v = 16'(m_en);
         3'd3: v = 16'(m_es);
         3'd4: begin
            for (int i = 0; i < N; i++) begin
               if (m_pend[i] && m_en[i] && v == 16'h0000) v = 16'h8000 + 16'(i);
            end
         end
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

   always @(posedge clk) begin : model
      logic [N-1:0] np, nen, nes;
      logic [15:0]  nrd;
      logic         nirq, wr, wanted, forced, cleared;
      if (reset) begin
         m_seen1 = '0; m_seen2 = '0; m_pend = '0; m_en = '0; m_es = '0;
         m_rd = 16'h0000; m_irq = 1'b0; m_live = 1'b1;
      end else begin
         wr   = chipselect && !write_n;
         nrd  = model_read(address);
         nirq = 1'b0;
         nen  = m_en;
         nes  = m_es;
         for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i]) nirq = 1'b1;
            wanted  = m_es[i] ? (m_seen1[i] && !m_seen2[i]) : m_seen1[i];
            forced  = wr && address == 3'd5 && writedata[i];
            cleared = wr && address == 3'd1 && writedata[i];
            np[i]   = wanted || forced || (m_pend[i] && !cleared);
         end
         if (wr && address == 3'd2) nen = writedata[N-1:0];
         if (wr && address == 3'd3) nes = writedata[N-1:0];
         m_seen2 = m_seen1;
         m_seen1 = src;
         m_pend  = np;
         m_en    = nen;
         m_es    = nes;
         m_rd    = nrd;
         m_irq   = nirq;
      end
   end

   // scoreboard: outputs against the model on every falling edge
   always @(negedge clk) begin
      if (m_live) begin
         n_checks++;
         if (readdata !== m_rd) begin
            n_errors++;
            $display("FAIL model_readdata t=%0t: got 0x%04h want 0x%04h", $time, readdata, m_rd);
         end
         n_checks++;
         if (irq !== m_irq) begin
            n_errors++;
            $display("FAIL model_irq t=%0t: got %0b want %0b", $time, irq, m_irq);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
      end
   endtask

   // driver tasks: every input change lands 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] v);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick(1);
      v = readdata;
      chipselect = 1'b0;
   endtask

   logic [15:0] rv;

   initial begin
      reset = 1'b1; src = '0; address = 3'd0; chipselect = 1'b0;
      write_n = 1'b1; writedata = 16'h0000;
      tick(2);
      reset = 1'b0;

      // reset state and reserved address
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), rv);
         check($sformatf("reset_read_a%0d", a), rv, 16'h0000);
      end
      check("reset_irq", {15'd0, irq}, 16'h0000);
      wr(3'd6, 16'hFFFF);
      rd(3'd6, rv);  check("reserved_read", rv, 16'h0000);

      // edge capture of a 1-cycle pulse
      wr(3'd2, 16'h0001);
      wr(3'd3, 16'h0001);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      check("edge_irq_after_e0", {15'd0, irq}, 16'h0000);
      tick(1);
      check("edge_irq_after_e1", {15'd0, irq}, 16'h0000);
      tick(1);
      check("edge_irq_after_e2", {15'd0, irq}, 16'h0001);
      rd(3'd1, rv);  check("edge_pending", rv, 16'h0001);
      wr(3'd1, 16'h0001);
      check("edge_irq_after_w", {15'd0, irq}, 16'h0001);
      tick(1);
      check("edge_irq_after_w1", {15'd0, irq}, 16'h0000);

      // level source holds its pending bit
      wr(3'd3, 16'h0000);
      wr(3'd2, 16'h0004);
      src = 8'h04;
      tick(3);
      check("level_irq_set", {15'd0, irq}, 16'h0001);
      wr(3'd1, 16'h0004);
      rd(3'd1, rv);  check("level_pending_held", rv, 16'h0004);
      check("level_irq_held", {15'd0, irq}, 16'h0001);
      src = 8'h00;
      tick(2);
      wr(3'd1, 16'h0004);
      rd(3'd1, rv);  check("level_pending_cleared", rv, 16'h0000);
      check("level_irq_cleared", {15'd0, irq}, 16'h0000);

      // priority encoding of ACTIVE
      wr(3'd5, 16'h0028);
      wr(3'd2, 16'h00FF);
      rd(3'd4, rv);  check("active_3", rv, 16'h8003);
      wr(3'd1, 16'h0008);
      rd(3'd4, rv);  check("active_5", rv, 16'h8005);
      wr(3'd2, 16'h0000);
      rd(3'd4, rv);  check("active_none", rv, 16'h0000);
      check("active_irq_masked", {15'd0, irq}, 16'h0000);
      rd(3'd1, rv);  check("masked_pending", rv, 16'h0020);
      rd(3'd5, rv);  check("force_reads_zero", rv, 16'h0000);

      // rising edge and W1C on the same cycle
      wr(3'd1, 16'h00FF);
      wr(3'd3, 16'h0002);
      wr(3'd5, 16'h0002);
      src = 8'h02;
      tick(1);
      wr(3'd1, 16'h0002);
      rd(3'd1, rv);  check("set_beats_clear", rv, 16'h0002);
      src = 8'h00;

      // reset in the middle of a FORCE write
      wr(3'd2, 16'h00FF);
      wr(3'd5, 16'h00FF);
      tick(1);
      check("pre_reset_irq", {15'd0, irq}, 16'h0001);
      rd(3'd1, rv);  check("pre_reset_pending", rv, 16'h00FF);
      address = 3'd5; writedata = 16'h00FF; chipselect = 1'b1; write_n = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      check("midreset_irq", {15'd0, irq}, 16'h0000);
      check("midreset_readdata", readdata, 16'h0000);
      rd(3'd1, rv);  check("midreset_pending", rv, 16'h0000);
      rd(3'd2, rv);  check("midreset_enable", rv, 16'h0000);
      check("midreset_irq_later", {15'd0, irq}, 16'h0000);

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Memory-mapped interrupt aggregator sitting directly downstream of the interval timer and the other peripheral interrupt sources. It captures up to `N_SRC` request lines, in edge or level mode, into sticky pending bits, masks them, and drives one registered interrupt line to the Nios II core. It also reports the highest-priority active source over a 16-bit Avalon-MM slave of the same shape as the timer's.

## Interface
Parameters:
- `N_SRC`, default 8: number of interrupt sources, 1..16. Source 0 is the timer `irq`.

Ports:
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `src`, in, `N_SRC`: raw interrupt requests, synchronous to `clk`.
- `address`, in, 3: register word select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 16: write data.
- `readdata`, out, 16: registered read data. Reset value 0.
- `irq`, out, 1: aggregated interrupt to the CPU, registered. Reset value 0.

## Operation
- Write strobe: `wr = chipselect && !write_n`. There is no read strobe. `readdata` reloads from the read mux every cycle.
- Register map. Bits at `N_SRC` and above read 0 and ignore writes. Reserved addresses read 0.
  - 0 STATUS (RO): `src_q`.
  - 1 PENDING: reads pending. Write-1-to-clear.
  - 2 ENABLE (RW): mask.
  - 3 EDGE_SEL (RW): per-bit mode, 1 = rising edge, 0 = level.
  - 4 ACTIVE (RO): bit 15 = valid. Bits 3:0 = lowest index `i` with `pending[i] & enable[i]`. Reads 0 when none.
  - 5 FORCE (WO): write-1 sets pending. Reads 0.
  - 6, 7: reserved.
- Source pipeline:
  - `src_q` registers `src`.
  - `src_d` registers `src_q`.
  - `rise = src_q & ~src_d`.
- Set vector: `set = (edge_sel & rise) | (~edge_sel & src_q) | force_bits`.
- Pending update: `pending <= (pending & ~clr) | set`, where `clr` is the PENDING write data.
- Set wins over a clear in the same cycle.
- A level source that is still high re-sets its pending bit, so it cannot be cleared until the source drops.
- `irq <= |(pending & enable)`.
- Changing ENABLE does not alter pending. A masked pending bit raises `irq` when it is later enabled.
- Changing EDGE_SEL takes effect on the next `set` evaluation. Pending is untouched.
- Reset zeroes: `src_q`, `src_d`, pending, ENABLE, EDGE_SEL, `readdata`, `irq`.

## Timing
- Source to `irq`: `src` sampled high at edge E0 → `src_q=1` after E0, pending set after E1, `irq=1` after E2.
- Clear to `irq`: PENDING W1C at edge W (source inactive) → pending clear after W, `irq` low after W+1.
- Read latency: `readdata` reflects the address presented at edge R, valid after R, so data is returned the next cycle.
  - The value is the register state before edge R. A simultaneous write to the same register is not visible.
- Edge mode captures one pulse per `0→1` transition of `src_q`. A 1-cycle pulse is captured. Back-to-back pulses need one low cycle between them.
- Reset asserted mid-operation forces all outputs to 0 on the next edge, regardless of pending, writes, or sources in that cycle.
- After reset deasserts, a source already high produces a rise on the first cycle, so edge-mode bits still capture it.

## Structure
- Shared package `irq_agg_pkg`:
  - Register address constants (`ADDR_STATUS` .. `ADDR_FORCE`).
  - `N_SRC_MAX = 16`.
  - ACTIVE valid bit position (15).
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder, `N_SRC` → {valid, 4-bit index}. Used for the ACTIVE read.
- The top level holds the source pipeline, the pending/mask/mode registers, the read mux and the `irq` register.

## Test plan
1. Reset: assert `reset` 2 cycles. Then every address reads 0x0000 and `irq=0`. Writing 0xFFFF to address 6 leaves reads at 0.
2. Edge capture: ENABLE=0x0001, EDGE_SEL=0x0001, 1-cycle pulse on `src[0]`. Required: PENDING reads 0x0001, `irq` rises 3 edges after the sample edge. W1C 0x0001 → `irq` low 2 edges later.
3. Level hold: EDGE_SEL=0, ENABLE=0x0004, hold `src[2]` high.
   - W1C 0x0004 → PENDING still 0x0004, `irq` stays 1.
   - Drop `src[2]`, wait 2 cycles, W1C → PENDING 0x0000, `irq=0`.
4. Priority: FORCE=0x0028, ENABLE=0x00FF. ACTIVE reads 0x8003. W1C 0x0008 → ACTIVE reads 0x8005. ENABLE=0 → ACTIVE 0x0000 and `irq=0`, PENDING still 0x0020.
5. Simultaneous set/clear: edge bit 1 rises in the same cycle as W1C 0x0002. Required: PENDING stays 0x0002.
6. Reset mid-operation: with PENDING=0x00FF and `irq=1`, assert `reset` for 1 cycle during a FORCE write. Required: PENDING, ENABLE and `irq` are all 0 on the next cycle.
